// File: rtl/cache_mem_sequencer_if.sv
// Word-level start/done handshake between the miss sequencer (master) and
// the ram_control responder (slave).
interface cache_mem_sequencer_if;
  logic        ram_wr_start;
  logic [31:0] ram_wr_addr_base;
  logic [31:0] ram_wr_data_in;
  logic        ram_wr_done;
  logic        ram_rd_start;
  logic [31:0] ram_rd_addr_base;
  logic [31:0] ram_rd_data_out;
  logic        ram_rd_done;

  modport master (
    output ram_wr_start,
    output ram_wr_addr_base,
    output ram_wr_data_in,
    input  ram_wr_done,
    output ram_rd_start,
    output ram_rd_addr_base,
    input  ram_rd_data_out,
    input  ram_rd_done
  );

  modport slave (
    input  ram_wr_start,
    input  ram_wr_addr_base,
    input  ram_wr_data_in,
    output ram_wr_done,
    input  ram_rd_start,
    input  ram_rd_addr_base,
    output ram_rd_data_out,
    output ram_rd_done
  );
endinterface

// File: rtl/cache_mem_sequencer.sv
// Cache miss sequencer: writes back a dirty victim line, then refills the
// missing line one word at a time over the ram_control start/done handshake.
module cache_mem_sequencer #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  input  logic                  miss_dirty,
  input  logic [31:0]           victim_addr,
  output logic [IDX_WIDTH-1:0]  victim_rd_idx,
  input  logic [31:0]           victim_rd_data,
  output logic                  fill_wr_en,
  output logic [IDX_WIDTH-1:0]  fill_wr_idx,
  output logic [31:0]           fill_wr_data,
  output logic                  busy,
  output logic                  miss_done,
  cache_mem_sequencer_if.master ram
);

  localparam int                   OFF_BITS  = IDX_WIDTH + 1;
  localparam logic [31:0]          BASE_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_ISSUE,
    WB_WAIT,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          miss_base_q, miss_base_d;
  logic [31:0]          victim_base_q, victim_base_d;
  logic                 wr_start_q, wr_start_d;
  logic [31:0]          wr_addr_q, wr_addr_d;
  logic [31:0]          wr_data_q, wr_data_d;
  logic                 rd_start_q, rd_start_d;
  logic [31:0]          rd_addr_q, rd_addr_d;

  // Halfword address of word idx within an aligned line.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [IDX_WIDTH-1:0] idx);
    return base + {{(31-IDX_WIDTH){1'b0}}, idx, 1'b0};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      wr_start_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_start_q    <= 1'b0;
      rd_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      miss_base_q   <= miss_base_d;
      victim_base_q <= victim_base_d;
      wr_start_q    <= wr_start_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_start_q    <= rd_start_d;
      rd_addr_q     <= rd_addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    miss_base_d   = miss_base_q;
    victim_base_d = victim_base_q;
    case (state_q)
      IDLE: begin
        if (miss_req) begin
          miss_base_d   = miss_addr & BASE_MASK;
          victim_base_d = victim_addr & BASE_MASK;
          cnt_d         = '0;
          state_d       = miss_dirty ? WB_ISSUE : RD_ISSUE;
        end
      end
      WB_ISSUE: state_d = WB_WAIT;
      WB_WAIT: begin
        if (ram.ram_wr_done) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = RD_ISSUE;
          end else begin
            cnt_d   = cnt_q + IDX_WIDTH'(1);
            state_d = WB_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (ram.ram_rd_done) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + IDX_WIDTH'(1);
            state_d = RD_ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue registers load on entry to an ISSUE state, so each start pulse shows
  // up together with its address/data and both hold until the matching done.
  always_comb begin
    wr_start_d = (state_d == WB_ISSUE);
    rd_start_d = (state_d == RD_ISSUE);
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    if (wr_start_d) begin
      wr_addr_d = word_addr(victim_base_d, cnt_d);
      wr_data_d = victim_rd_data;
    end
    if (rd_start_d) begin
      rd_addr_d = word_addr(miss_base_d, cnt_d);
    end
  end

  always_comb begin
    victim_rd_idx        = cnt_d;
    busy                 = (state_q != IDLE);
    miss_done            = (state_q == DONE);
    fill_wr_en           = (state_q == RD_WAIT) && ram.ram_rd_done;
    fill_wr_idx          = fill_wr_en ? cnt_q : '0;
    fill_wr_data         = fill_wr_en ? ram.ram_rd_data_out : '0;
    ram.ram_wr_start     = wr_start_q;
    ram.ram_wr_addr_base = wr_addr_q;
    ram.ram_wr_data_in   = wr_data_q;
    ram.ram_rd_start     = rd_start_q;
    ram.ram_rd_addr_base = rd_addr_q;
  end

endmodule

// File: tb/tb_cache_mem_sequencer.sv
// Directed bench for cache_mem_sequencer: table of miss vectors against a word
// RAM responder model, plus reset-mid-miss and back-to-back sequences.
module tb_cache_mem_sequencer;

  logic        clk;
  logic        reset_n;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_dirty;
  logic [31:0] victim_addr;
  logic [1:0]  victim_rd_idx;
  logic [31:0] victim_rd_data;
  logic        fill_wr_en;
  logic [1:0]  fill_wr_idx;
  logic [31:0] fill_wr_data;
  logic        busy;
  logic        miss_done;

  cache_mem_sequencer_if bus();

  cache_mem_sequencer #(.LINE_WORDS(4), .IDX_WIDTH(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .miss_req      (miss_req),
    .miss_addr     (miss_addr),
    .miss_dirty    (miss_dirty),
    .victim_addr   (victim_addr),
    .victim_rd_idx (victim_rd_idx),
    .victim_rd_data(victim_rd_data),
    .fill_wr_en    (fill_wr_en),
    .fill_wr_idx   (fill_wr_idx),
    .fill_wr_data  (fill_wr_data),
    .busy          (busy),
    .miss_done     (miss_done),
    .ram           (bus)
  );

  typedef struct {
    logic [31:0] miss_addr;
    logic [31:0] victim_addr;
    logic        dirty;
    int          lat;
    logic [31:0] vic_word;
    logic        spurious;
    logic [31:0] exp_rd_base;
    logic [31:0] exp_wr_base;
    int          exp_cycles;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          lat_cfg = 1;
  logic        spur_mode = 1'b0;
  logic [31:0] cur_vic_word = '0;
  logic        rsp_rd_done, rsp_wr_done, spur_rd, spur_wr;
  logic [31:0] rsp_rd_data;
  logic [31:0] mem [0:8191];
  logic [31:0] rd_addr_q[$], wr_addr_q[$], wr_data_q[$], fill_idx_q[$], fill_data_q[$];
  logic        rd_out, wr_out, prev_rd, prev_wr;
  logic [31:0] rd_hold, wr_hold, wd_hold;
  vec_t        vecs[6];

  assign victim_rd_data      = cur_vic_word + 32'(victim_rd_idx);
  assign bus.ram_rd_done     = rsp_rd_done | spur_rd;
  assign bus.ram_wr_done     = rsp_wr_done | spur_wr;
  assign bus.ram_rd_data_out = rsp_rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input logic [12:0] i);
    if (i == 13'd4086) return 32'hAABBCCDD;
    return {3'b101, i, 3'b000, i};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_miss_done"}, 32'(miss_done), 32'd0);
    check_output({tag, "_fill_en"}, 32'(fill_wr_en), 32'd0);
    check_output({tag, "_fill_idx"}, 32'(fill_wr_idx), 32'd0);
    check_output({tag, "_fill_data"}, fill_wr_data, 32'd0);
    check_output({tag, "_victim_idx"}, 32'(victim_rd_idx), 32'd0);
    check_output({tag, "_wr_start"}, 32'(bus.ram_wr_start), 32'd0);
    check_output({tag, "_rd_start"}, 32'(bus.ram_rd_start), 32'd0);
    check_output({tag, "_wr_addr"}, bus.ram_wr_addr_base, 32'd0);
    check_output({tag, "_wr_data"}, bus.ram_wr_data_in, 32'd0);
    check_output({tag, "_rd_addr"}, bus.ram_rd_addr_base, 32'd0);
  endtask

  task automatic clear_log();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    fill_idx_q.delete();
    fill_data_q.delete();
    done_cnt = 0;
  endtask

  // Responder: done arrives lat cycles after the start cycle; in spurious mode
  // both dones are also pulsed during the start (ISSUE) cycle itself.
  initial begin
    logic        is_rd;
    logic [31:0] a, d;
    int          l;
    rsp_rd_done = 1'b0;
    rsp_wr_done = 1'b0;
    rsp_rd_data = '0;
    spur_rd     = 1'b0;
    spur_wr     = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = mem_init(13'(i));
    forever begin
      @(negedge clk);
      if (reset_n && (bus.ram_rd_start || bus.ram_wr_start)) begin
        is_rd = bus.ram_rd_start;
        a = is_rd ? bus.ram_rd_addr_base : bus.ram_wr_addr_base;
        d = bus.ram_wr_data_in;
        l = (lat_cfg == 0) ? int'($urandom_range(1, 10)) : lat_cfg;
        if (spur_mode) begin
          spur_rd = 1'b1;
          spur_wr = 1'b1;
        end
        for (int i = 0; i < l; i++) begin
          @(posedge clk);
          #1;
          spur_rd = 1'b0;
          spur_wr = 1'b0;
        end
        if (is_rd) begin
          rsp_rd_data = mem[a[12:0]];
          rsp_rd_done = 1'b1;
        end else begin
          mem[a[12:0]] = d;
          rsp_wr_done = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_rd_done = 1'b0;
        rsp_wr_done = 1'b0;
        rsp_rd_data = '0;
      end
    end
  end

  // Bus monitor: logs transactions and checks pulse width, overlap, stability
  // and that fills happen only on a genuine read completion.
  initial begin
    rd_out = 1'b0; wr_out = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
    rd_hold = '0; wr_hold = '0; wd_hold = '0;
  end

  always @(negedge clk) begin
    if (miss_done) done_cnt++;
    if (!reset_n) begin
      rd_out = 1'b0; wr_out = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
    end else begin
      check_output("start_overlap", 32'(bus.ram_rd_start & bus.ram_wr_start), 32'd0);
      check_output("fill_qualified", 32'(fill_wr_en),
                   32'(rd_out && bus.ram_rd_done && !bus.ram_rd_start));
      if (prev_rd) check_output("rd_start_width", 32'(bus.ram_rd_start), 32'd0);
      if (prev_wr) check_output("wr_start_width", 32'(bus.ram_wr_start), 32'd0);
      if (fill_wr_en) begin
        fill_idx_q.push_back(32'(fill_wr_idx));
        fill_data_q.push_back(fill_wr_data);
      end
      if (bus.ram_rd_start) begin
        check_output("rd_one_outstanding", 32'({rd_out, wr_out}), 32'd0);
        rd_addr_q.push_back(bus.ram_rd_addr_base);
        rd_hold = bus.ram_rd_addr_base;
        rd_out  = 1'b1;
      end else if (rd_out) begin
        check_output("rd_addr_stable", bus.ram_rd_addr_base, rd_hold);
        if (bus.ram_rd_done) rd_out = 1'b0;
      end
      if (bus.ram_wr_start) begin
        check_output("wr_one_outstanding", 32'({rd_out & ~bus.ram_rd_start, wr_out}), 32'd0);
        wr_addr_q.push_back(bus.ram_wr_addr_base);
        wr_data_q.push_back(bus.ram_wr_data_in);
        wr_hold = bus.ram_wr_addr_base;
        wd_hold = bus.ram_wr_data_in;
        wr_out  = 1'b1;
      end else if (wr_out) begin
        check_output("wr_addr_stable", bus.ram_wr_addr_base, wr_hold);
        check_output("wr_data_stable", bus.ram_wr_data_in, wd_hold);
        if (bus.ram_wr_done) wr_out = 1'b0;
      end
      prev_rd = bus.ram_rd_start;
      prev_wr = bus.ram_wr_start;
    end
  end

  task automatic apply_stimulus(input int vi, input vec_t v);
    int          n;
    logic        seen;
    logic [31:0] ea;
    clear_log();
    lat_cfg      = v.lat;
    spur_mode    = v.spurious;
    cur_vic_word = v.vic_word;
    @(negedge clk);
    if (v.spurious) begin
      spur_rd = 1'b1;
      spur_wr = 1'b1;
      @(negedge clk);
      spur_rd = 1'b0;
      spur_wr = 1'b0;
      @(negedge clk);
      check_output($sformatf("v%0d_idle_spurious_busy", vi), 32'(busy), 32'd0);
    end
    miss_addr   = v.miss_addr;
    victim_addr = v.victim_addr;
    miss_dirty  = v.dirty;
    miss_req    = 1'b1;
    @(posedge clk);
    #1;
    miss_req = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      if (n == 1) check_output($sformatf("v%0d_busy_rise", vi), 32'(busy), 32'd1);
      if (v.spurious) miss_req = (n >= 3 && n <= 5);
      if (miss_done) seen = 1'b1;
    end
    miss_req = 1'b0;
    check_output($sformatf("v%0d_done_seen", vi), 32'(seen), 32'd1);
    if (v.exp_cycles != 0)
      check_output($sformatf("v%0d_done_cycle", vi), 32'(n), 32'(v.exp_cycles));
    @(negedge clk);
    check_output($sformatf("v%0d_busy_fall", vi), 32'(busy), 32'd0);
    check_output($sformatf("v%0d_done_width", vi), 32'(miss_done), 32'd0);
    repeat (3) @(negedge clk);
    check_output($sformatf("v%0d_done_count", vi), 32'(done_cnt), 32'd1);
    check_output($sformatf("v%0d_rd_count", vi), 32'(rd_addr_q.size()), 32'd4);
    check_output($sformatf("v%0d_fill_count", vi), 32'(fill_idx_q.size()), 32'd4);
    check_output($sformatf("v%0d_wr_count", vi), 32'(wr_addr_q.size()), v.dirty ? 32'd4 : 32'd0);
    for (int k = 0; k < 4; k++) begin
      ea = v.exp_rd_base + 32'(2 * k);
      if (k < rd_addr_q.size())
        check_output($sformatf("v%0d_rd_addr%0d", vi, k), rd_addr_q[k], ea);
      if (k < fill_idx_q.size()) begin
        check_output($sformatf("v%0d_fill_idx%0d", vi, k), fill_idx_q[k], 32'(k));
        check_output($sformatf("v%0d_fill_data%0d", vi, k), fill_data_q[k], mem_init(ea[12:0]));
      end
      if (v.dirty) begin
        ea = v.exp_wr_base + 32'(2 * k);
        if (k < wr_addr_q.size()) begin
          check_output($sformatf("v%0d_wr_addr%0d", vi, k), wr_addr_q[k], ea);
          check_output($sformatf("v%0d_wr_data%0d", vi, k), wr_data_q[k], v.vic_word + 32'(k));
        end
        check_output($sformatf("v%0d_readback%0d", vi, k), mem[ea[12:0]], v.vic_word + 32'(k));
      end
    end
  endtask

  initial begin
    int   n;
    logic seen;
    reset_n     = 1'b0;
    miss_req    = 1'b0;
    miss_addr   = '0;
    miss_dirty  = 1'b0;
    victim_addr = '0;

    vecs[0] = '{32'd4086,       32'd0,          1'b0, 1, 32'h0,        1'b0, 32'd4080,     32'd0,          9};
    vecs[1] = '{32'd8,          32'd55,         1'b1, 1, 32'h11110000, 1'b0, 32'd8,        32'd48,         17};
    vecs[2] = '{32'd100,        32'd203,        1'b1, 3, 32'hCAFE0000, 1'b0, 32'd96,       32'd200,        33};
    vecs[3] = '{32'h0001_0005,  32'd0,          1'b0, 0, 32'h0,        1'b0, 32'h0001_0000, 32'd0,         0};
    vecs[4] = '{32'h0000_0305,  32'hFFFF_FFF9,  1'b1, 0, 32'h5EED0000, 1'b0, 32'h0000_0300, 32'hFFFF_FFF8, 0};
    vecs[5] = '{32'h0000_0202,  32'd0,          1'b0, 4, 32'h0,        1'b1, 32'h0000_0200, 32'd0,         21};

    repeat (2) @(negedge clk);
    outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    outputs_zero("post_reset_idle");

    // Reset while a refill word is outstanding: no miss_done, everything clears.
    clear_log();
    lat_cfg   = 5;
    spur_mode = 1'b0;
    miss_addr = 32'h0000_0503;
    miss_req  = 1'b1;
    @(posedge clk);
    #1;
    miss_req = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pre_reset_busy", 32'(busy), 32'd1);
    check_output("pre_reset_rd_addr", bus.ram_rd_addr_base, 32'h0000_0500);
    reset_n = 1'b0;
    #1;
    outputs_zero("mid_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_output("reset_no_done", 32'(done_cnt), 32'd0);
    check_output("reset_idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) apply_stimulus(i, vecs[i]);

    // Back-to-back: miss_req held through DONE, second miss after one idle cycle.
    clear_log();
    lat_cfg    = 1;
    spur_mode  = 1'b0;
    @(negedge clk);
    miss_addr  = 32'd4086;
    miss_dirty = 1'b0;
    miss_req   = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (miss_done) seen = 1'b1;
    end
    check_output("b2b_first_done_cycle", 32'(n), 32'd9);
    miss_addr = 32'h0000_0403;
    @(negedge clk);
    check_output("b2b_idle_busy", 32'(busy), 32'd0);
    check_output("b2b_idle_rd_start", 32'(bus.ram_rd_start), 32'd0);
    @(negedge clk);
    check_output("b2b_second_rd_start", 32'(bus.ram_rd_start), 32'd1);
    check_output("b2b_second_rd_addr", bus.ram_rd_addr_base, 32'h0000_0400);
    miss_req = 1'b0;
    n = 11;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (miss_done) seen = 1'b1;
    end
    check_output("b2b_second_done_cycle", 32'(n), 32'd19);
    repeat (3) @(negedge clk);
    check_output("b2b_done_count", 32'(done_cnt), 32'd2);
    check_output("b2b_rd_count", 32'(rd_addr_q.size()), 32'd8);
    if (rd_addr_q.size() == 8)
      check_output("b2b_last_rd_addr", rd_addr_q[7], 32'h0000_0406);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
